load_merge: RTL and testbench

LOAD_MERGE -- requirements
Module: load_merge

---
 rtl/load_merge_if.sv | 26 ++
 rtl/load_merge.sv | 134 +++++++++++++
 tb/tb_load_merge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_merge_if.sv
// Load-response handshake bundle between the load unit (master) and load_merge (slave).
interface load_merge_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_mem_data;
  logic [31:0] in_rt_old;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_wen;
  logic [4:0]  out_dest;
  logic        out_err;

  modport slave (
    input  in_valid, in_op, in_addr_lo, in_mem_data, in_rt_old, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_wen, out_dest, out_err
  );

  modport master (
    output in_valid, in_op, in_addr_lo, in_mem_data, in_rt_old, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_wen, out_dest, out_err
  );
endinterface

// File: rtl/load_merge.sv
// Load-data align/extend/merge stage with a 2-entry result FIFO.
// Define LOAD_MERGE_LWLR_EN to support LWL/LWR; otherwise ops 5/6 are reserved.
module load_merge (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  load_merge_if.slave   bus
);
  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_WEN  = 4;
  localparam int unsigned W_DEST = 5;
  localparam int unsigned W_CNT  = 2;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
`ifdef LOAD_MERGE_LWLR_EN
  localparam logic [2:0] OP_LWL = 3'd5;
  localparam logic [2:0] OP_LWR = 3'd6;
`endif

  typedef struct packed {
    logic [W_DATA-1:0] data;
    logic [W_WEN-1:0]  wen;
    logic [W_DEST-1:0] dest;
    logic              err;
  } entry_t;

  entry_t             r_mem [0:1];
  logic               r_wptr;
  logic               r_rptr;
  logic [W_CNT-1:0]   r_count;

  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [W_DATA-1:0]  w_data;
  logic [W_WEN-1:0]   w_wen;
  logic               w_err;
  logic               w_push;
  logic               w_pop;
  entry_t             w_head;

  // Result formation from the incoming response, captured at accept time.
  always_comb begin
    w_data = '0;
    w_wen  = '0;
    w_err  = 1'b0;
    case (bus.in_addr_lo)
      2'd0:    w_byte = bus.in_mem_data[7:0];
      2'd1:    w_byte = bus.in_mem_data[15:8];
      2'd2:    w_byte = bus.in_mem_data[23:16];
      default: w_byte = bus.in_mem_data[31:24];
    endcase
    w_half = bus.in_addr_lo[1] ? bus.in_mem_data[31:16] : bus.in_mem_data[15:0];
    case (bus.in_op)
      OP_LB:  begin w_data = {{24{w_byte[7]}}, w_byte}; w_wen = 4'b1111; end
      OP_LBU: begin w_data = {24'd0, w_byte};           w_wen = 4'b1111; end
      OP_LH, OP_LHU: begin
        if (bus.in_addr_lo[0]) begin
          w_err = 1'b1;
        end else begin
          w_data = (bus.in_op == OP_LH) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
          w_wen  = 4'b1111;
        end
      end
      OP_LW: begin
        if (bus.in_addr_lo != 2'd0) begin
          w_err = 1'b1;
        end else begin
          w_data = bus.in_mem_data;
          w_wen  = 4'b1111;
        end
      end
`ifdef LOAD_MERGE_LWLR_EN
      // Unaligned-word halves: memory bytes land high (LWL) or low (LWR), rt fills the rest.
      OP_LWL: begin
        case (bus.in_addr_lo)
          2'd0:    begin w_data = {bus.in_mem_data[7:0],  bus.in_rt_old[23:0]}; w_wen = 4'b1000; end
          2'd1:    begin w_data = {bus.in_mem_data[15:0], bus.in_rt_old[15:0]}; w_wen = 4'b1100; end
          2'd2:    begin w_data = {bus.in_mem_data[23:0], bus.in_rt_old[7:0]};  w_wen = 4'b1110; end
          default: begin w_data = bus.in_mem_data;                              w_wen = 4'b1111; end
        endcase
      end
      OP_LWR: begin
        case (bus.in_addr_lo)
          2'd0:    begin w_data = bus.in_mem_data;                               w_wen = 4'b1111; end
          2'd1:    begin w_data = {bus.in_rt_old[31:24], bus.in_mem_data[31:8]};  w_wen = 4'b0111; end
          2'd2:    begin w_data = {bus.in_rt_old[31:16], bus.in_mem_data[31:16]}; w_wen = 4'b0011; end
          default: begin w_data = {bus.in_rt_old[31:8],  bus.in_mem_data[31:24]}; w_wen = 4'b0001; end
        endcase
      end
`endif
      default: w_err = 1'b1;
    endcase
  end

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  // FIFO storage and pointers; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{data: w_data, wen: w_wen, dest: bus.in_dest, err: w_err};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + W_CNT'(1);
        2'b01:   r_count <= r_count - W_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head        = r_mem[r_rptr];
  assign bus.in_ready  = (r_count < W_CNT'(2));
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = bus.out_valid ? w_head.data : '0;
  assign bus.out_wen   = bus.out_valid ? w_head.wen  : '0;
  assign bus.out_dest  = bus.out_valid ? w_head.dest : '0;
  assign bus.out_err   = bus.out_valid ? w_head.err  : 1'b0;
endmodule

// File: tb/tb_load_merge.sv
// Directed bench for load_merge: queue-based reference model checked every cycle plus literal vectors.
module tb_load_merge;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  load_merge_if bus ();

  load_merge dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  w;
    logic [4:0]  dst;
    logic        e;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour expressed as byte shifts and masks.
  function automatic ent_t model(input logic [2:0] op, input logic [1:0] a,
                                 input logic [31:0] mem, input logic [31:0] rt,
                                 input logic [4:0] dst);
    ent_t e;
    int unsigned ai;
    logic [31:0] sh;
    logic [7:0]  wl;
    ai = 32'(a);
    sh = mem >> (8 * ai);
    e = '0;
    e.dst = dst;
    case (op)
      3'd0: begin e.d = 32'(signed'(sh[7:0]));  e.w = 4'hF; end
      3'd1: begin e.d = sh & 32'h0000_00FF;     e.w = 4'hF; end
      3'd2, 3'd3: begin
        if (ai % 2 == 1) e.e = 1'b1;
        else begin
          e.d = (op == 3'd2) ? 32'(signed'(sh[15:0])) : (sh & 32'h0000_FFFF);
          e.w = 4'hF;
        end
      end
      3'd4: begin
        if (ai != 0) e.e = 1'b1;
        else begin e.d = mem; e.w = 4'hF; end
      end
`ifdef LOAD_MERGE_LWLR_EN
      3'd5: begin
        e.d = (mem << (8 * (3 - ai))) | (rt & (32'hFFFF_FFFF >> (8 * (ai + 1))));
        wl  = 8'h0F << (3 - ai);
        e.w = wl[3:0];
      end
      3'd6: begin
        e.d = (mem >> (8 * ai)) | (rt & ~(32'hFFFF_FFFF >> (8 * ai)));
        e.w = 4'hF >> ai;
      end
`endif
      default: e.e = 1'b1;
    endcase
    if (e.e) begin e.d = '0; e.w = '0; end
    return e;
  endfunction

  // Model state update at the same edges the DUT uses.
  always @(posedge clk or posedge rst) begin
    logic acc, pp;
    if (rst || flush) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && bus.out_ready;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(model(bus.in_op, bus.in_addr_lo, bus.in_mem_data, bus.in_rt_old, bus.in_dest));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    ent_t h;
    if (!rst) begin
      h = (q.size() > 0) ? q[0] : '0;
      chk("m_in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
      chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("m_out_data",  bus.out_data,       h.d);
      chk("m_out_wen",   32'(bus.out_wen),   32'(h.w));
      chk("m_out_dest",  32'(bus.out_dest),  32'(h.dst));
      chk("m_out_err",   32'(bus.out_err),   32'(h.e));
    end
  end

  // Directed vectors: op, addr, mem, rt, expected data/wen/err.
  localparam int NV = 15;
  logic [2:0]  v_op  [NV] = '{3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd7, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd0, 3'd5, 3'd6};
  logic [1:0]  v_a   [NV] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
  logic [31:0] v_mem [NV] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'h80000000, 32'h80000000, 32'hAABBCCDD,
                              32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD,
                              32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD};
`ifdef LOAD_MERGE_LWLR_EN
  logic [31:0] v_d   [NV] = '{32'hCCDD3344, 32'h1122AABB, 32'hFFFFFF80, 32'h00000080, 32'h0,
                              32'h0, 32'hFFFFAABB, 32'h0000CCDD, 32'hAABBCCDD, 32'h0,
                              32'hAABBCCDD, 32'hAABBCCDD, 32'hFFFFFFCC, 32'hDD223344, 32'h112233AA};
  logic [3:0]  v_w   [NV] = '{4'b1100, 4'b0011, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0,
                              4'hF, 4'hF, 4'hF, 4'b1000, 4'b0001};
  logic        v_e   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
  logic [31:0] v_d   [NV] = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'h0,
                              32'h0, 32'hFFFFAABB, 32'h0000CCDD, 32'hAABBCCDD, 32'h0,
                              32'h0, 32'h0, 32'hFFFFFFCC, 32'h0, 32'h0};
  logic [3:0]  v_w   [NV] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0,
                              4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
  logic        v_e   [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

  task automatic set_in(input logic v, input logic [2:0] op, input logic [1:0] a,
                        input logic [31:0] mem, input logic [4:0] dst);
    bus.in_valid    = v;
    bus.in_op       = op;
    bus.in_addr_lo  = a;
    bus.in_mem_data = mem;
    bus.in_rt_old   = 32'h11223344;
    bus.in_dest     = dst;
  endtask

  initial begin
    logic [4:0] popped[$];
    logic drop;
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 3'd0, 2'd0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    rst = 1'b0;

    // Literal vectors, one per cycle with the sink always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      set_in(1'b1, v_op[i], v_a[i], v_mem[i], 5'(i));
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  bus.out_data,       v_d[i]);
      chk($sformatf("vec%0d_wen", i),   32'(bus.out_wen),   32'(v_w[i]));
      chk($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(v_e[i]));
    end
    @(negedge clk);

    // Backpressure: three back-to-back pushes into a stalled sink, then drain.
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'd4, 2'd0, 32'h0000_0010, 5'd10);
    @(negedge clk);
    set_in(1'b1, 3'd4, 2'd0, 32'h0000_0011, 5'd11);
    @(negedge clk);
    set_in(1'b1, 3'd4, 2'd0, 32'h0000_0012, 5'd12);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_dest",     32'(bus.out_dest), 32'd10);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) popped.push_back(bus.out_dest);
      drop = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (drop) bus.in_valid = 1'b0;
    end
    chk("bp_pop_count", 32'(popped.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < popped.size()) ? 32'(popped[k]) : 32'hFFFF_FFFF, 32'(10 + k));

    // Flush while full with a concurrent push.
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'd0, 2'd0, 32'h0000_0001, 5'd20);
    @(negedge clk);
    set_in(1'b1, 3'd0, 2'd1, 32'h0000_0200, 5'd21);
    @(negedge clk);
    set_in(1'b1, 3'd0, 2'd2, 32'h0003_0000, 5'd22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);

    // Mixed traffic with irregular valid/ready and a flush in the middle.
    for (int c = 0; c < 24; c++) begin
      set_in((c % 4) != 3, 3'(c % 8), 2'((c * 3) % 4), 32'h8F0071A5 ^ (32'(c) * 32'h01010101), 5'(c));
      bus.in_rt_old = 32'h5A5AC3C3 + 32'(c);
      bus.out_ready = (c % 5) > 1;
      flush = (c == 13);
      @(negedge clk);
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream, checked between clock edges.
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'd4, 2'd0, 32'hDEADBEEF, 5'd7);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_data",  bus.out_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
